// File: rtl/hist_bin_accum.sv
// hist_bin_accum
// 8-bin luma histogram. Pixels between sof and eof are binned by
// pix_data[7:5] into CNT_W-bit counters. After eof the block finds the
// tallest bin (MAX, 8 cycles). It then derives a right shift that fits that
// bin into 8 bits (SHIFT, 1 cycle). It writes one scaled height per bin into
// id_value (SCALE, 8 cycles), and pulses id_valid in DONE. The latency from
// the cycle that carries eof to the id_valid cycle is always 18 cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   sof        start-of-frame strobe (one cycle)
//   eof        end-of-frame strobe (one cycle, never carries a pixel)
//   pix_data   pixel luma; bin = pix_data[7:5]
//   pix_valid  pix_data qualifier. There is no back-pressure: a pixel is
//              consumed in any cycle where pix_valid is high and the block
//              is accumulating. While busy is high, all frame inputs are
//              dropped.
//   id_value   8 bin heights, bin 0 in [63:56] ... bin 7 in [7:0]. The
//              value holds between frames.
//   id_valid   one-cycle strobe; id_value is valid from this cycle on.
//   busy       high in MAX, SHIFT, SCALE and DONE.
//   state_dbg  current FSM state encoding, for observation.
//
// Configuration macro HIST_ACCUM_SAT_EN: when defined, counters saturate at
// 2^CNT_W-1. When it is undefined, counters wrap modulo 2^CNT_W.

module hist_bin_accum #(
  parameter int CNT_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sof,
  input  logic        eof,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic [63:0] id_value,
  output logic        id_valid,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_MAX   = 3'd2,
    S_SHIFT = 3'd3,
    S_SCALE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt [8];
  logic [CNT_W-1:0] max_r;
  logic [4:0]       shift_r;
  logic [4:0]       shift_nxt;
  logic [4:0]       msb_pos;
  logic [2:0]       idx;
  logic [CNT_W-1:0] scaled;
  logic             accept_sof;
  logic             count_en;
  logic [2:0]       bin;

  // sof restarts a frame from IDLE or mid-ACCUM and takes priority over eof.
  // A pixel arriving with sof is counted as the first pixel of the new frame.
  // A pixel arriving with eof (and no sof) is dropped.
  assign accept_sof = sof && (state == S_IDLE || state == S_ACCUM);
  assign count_en   = pix_valid && (accept_sof || (state == S_ACCUM && !eof));
  assign bin        = pix_data[7:5];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sof) state_nxt = S_ACCUM;
      S_ACCUM: if (!sof && eof) state_nxt = S_MAX;
      S_MAX:   if (idx == 3'd7) state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = S_SCALE;
      S_SCALE: if (idx == 3'd7) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign id_valid  = (state == S_DONE);
  assign busy      = (state == S_MAX) || (state == S_SHIFT) ||
                     (state == S_SCALE) || (state == S_DONE);
  assign state_dbg = state;

  // Bin counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 8; b++) cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (accept_sof) begin
          cnt[b] <= {{(CNT_W-1){1'b0}}, (count_en && bin == 3'(b))};
        end else if (count_en && bin == 3'(b)) begin
`ifdef HIST_ACCUM_SAT_EN
          if (cnt[b] != {CNT_W{1'b1}}) cnt[b] <= cnt[b] + 1'b1;
`else
          cnt[b] <= cnt[b] + 1'b1;
`endif
        end
      end
    end
  end

  // Bin walker shared by MAX and SCALE. It wraps from 7 back to 0 on its own
  // between the two phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    idx <= '0;
    else if (state == S_MAX || state == S_SCALE) idx <= idx + 3'd1;
    else                                        idx <= '0;
  end

  // Running maximum, restarted while accumulating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_r <= '0;
    end else if (state == S_ACCUM) begin
      max_r <= '0;
    end else if (state == S_MAX && cnt[idx] > max_r) begin
      max_r <= cnt[idx];
    end
  end

  // Shift that keeps the tallest bin within 8 bits: MSB position minus 7.
  always_comb begin
    msb_pos = 5'd0;
    for (int i = 0; i < CNT_W; i++) begin
      if (max_r[i]) msb_pos = 5'(i);
    end
    shift_nxt = (msb_pos > 5'd7) ? (msb_pos - 5'd7) : 5'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   shift_r <= '0;
    else if (state == S_SHIFT) shift_r <= shift_nxt;
  end

  assign scaled = cnt[idx] >> shift_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_value <= '0;
    end else if (state == S_SCALE) begin
      for (int b = 0; b < 8; b++) begin
        if (idx == 3'(b)) id_value[(7-b)*8 +: 8] <= scaled[7:0];
      end
    end
  end

endmodule

// File: tb/tb_hist_bin_accum.sv
module tb_hist_bin_accum;

  localparam int TB_CNT_W = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        sof, eof, pix_valid;
  logic [7:0]  pix_data;
  logic [63:0] id_value;
  logic        id_valid, busy;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] last_val = '0;

  int unsigned m_cnt [8];
  bit          m_acc = 0;

  hist_bin_accum #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .sof(sof), .eof(eof),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .id_value(id_value), .id_valid(id_valid), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  task automatic bump(input logic [2:0] b);
`ifdef HIST_ACCUM_SAT_EN
    if (m_cnt[b] < (2**TB_CNT_W) - 1) m_cnt[b]++;
`else
    m_cnt[b] = (m_cnt[b] + 1) % (2**TB_CNT_W);
`endif
  endtask

  function automatic logic [63:0] model_result();
    int unsigned mx = 0;
    int s = 0;
    logic [63:0] v = '0;
    for (int b = 0; b < 8; b++) if (m_cnt[b] > mx) mx = m_cnt[b];
    while ((mx >> s) > 255) s++;
    for (int b = 0; b < 8; b++) v[(7-b)*8 +: 8] = 8'(m_cnt[b] >> s);
    return v;
  endfunction

  // drivers
  task automatic drive(input logic s, input logic e, input logic v, input logic [7:0] d);
    @(negedge clk);
    sof = s; eof = e; pix_valid = v; pix_data = d;
    if (s) begin
      for (int b = 0; b < 8; b++) m_cnt[b] = 0;
      m_acc = 1;
      if (v) bump(d[7:5]);
    end else if (m_acc && e) begin
      exp_q.push_back(model_result());
      m_acc = 0;
    end else if (m_acc && v) begin
      bump(d[7:5]);
    end
  endtask

  // Called right after eof was driven; watches for the result strobe.
  task automatic wait_result(input bit poke);
    bit seen = 0;
    logic [63:0] e;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      sof = 0; eof = 0; pix_valid = 0;
      if (k == 1) check("busy_after_eof", busy, 1);
      if (poke && k == 5) begin
        sof = 1; eof = 1; pix_valid = 1; pix_data = 8'h20;
      end
      if (id_valid) begin
        seen = 1;
        check("latency", k, 18);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("id_value", id_value, e);
          last_val = e;
        end else begin
          check("unexpected_result", 1, 0);
        end
      end
    end
    if (!seen) check("id_valid_timeout", 0, 1);
    @(negedge clk);
    check("id_valid_one_cycle", id_valid, 0);
    check("idle_after_done", state_dbg, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    bit saw_valid;
    rst = 1; sof = 0; eof = 0; pix_valid = 0; pix_data = '0;
    repeat (3) @(negedge clk);
    check("reset_id_value", id_value, 64'h0);
    check("reset_id_valid", id_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_state", state_dbg, 0);
    rst = 0;

    // IDLE ignores pixels and eof
    drive(0, 0, 1, 8'h00);
    drive(0, 1, 1, 8'h00);
    drive(0, 0, 0, 8'h00);
    check("idle_ignores_eof", state_dbg, 0);

    // 100 x bin0, 50 x bin7
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 100; i++) drive(0, 0, 1, 8'h00);
    for (int i = 0; i < 50; i++) drive(0, 0, 1, 8'hE0);
    drive(0, 1, 0, 8'h00);
    wait_result(0);
    check("frame_100_50", id_value, {8'd100, 48'h0, 8'd50});
    repeat (4) drive(0, 0, 0, 8'h00);
    check("id_value_holds", id_value, last_val);

    // 1000 x bin2 and 300 x bin5, interleaved; first pixel rides with sof
    begin
      int n2 = 999, n5 = 300;
      drive(1, 0, 1, 8'h40 | 8'($urandom_range(0, 31)));
      check("id_value_holds_in_accum", id_value, last_val);
      while (n2 + n5 > 0) begin
        if (n5 == 0 || (n2 > 0 && $urandom_range(0, 99) < 77)) begin
          drive(0, 0, 1, 8'h40 | 8'($urandom_range(0, 31))); n2--;
        end else begin
          drive(0, 0, 1, 8'hA0 | 8'($urandom_range(0, 31))); n5--;
        end
      end
      drive(0, 1, 0, 8'h00);
      wait_result(0);
      check("scaled_250_75", id_value, 64'h0000_FA00_004B_0000);
    end

    // empty frame; pixel arriving with eof is dropped
    drive(1, 0, 0, 8'h00);
    drive(0, 1, 1, 8'hE0);
    wait_result(0);
    check("empty_frame", id_value, 64'h0);

    // sof restarts mid-frame, and wins over eof in the same cycle
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 8'h20);
    drive(1, 1, 1, 8'h40);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 8'h40);
    drive(0, 1, 0, 8'h00);
    wait_result(0);
    check("restart_bin2_7", id_value, 64'h0000_0700_0000_0000);

    // random frames; inputs poked while busy must be ignored
    for (int f = 0; f < 3; f++) begin
      int n = $urandom_range(50, 300);
      drive(1, 0, 0, 8'h00);
      for (int i = 0; i < n; i++)
        drive(0, 0, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
      drive(0, 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      wait_result(f == 1);
    end

    // counter overflow: 2^CNT_W + 5 pixels into bin 3
    drive(1, 0, 1, 8'h60);
    for (int i = 1; i < (2**TB_CNT_W) + 5; i++) drive(0, 0, 1, 8'h60);
    drive(0, 1, 0, 8'h00);
    wait_result(0);
`ifdef HIST_ACCUM_SAT_EN
    check("overflow_bin3", id_value[39:32], 8'd255);
`else
    check("overflow_bin3", id_value[39:32], 8'd5);
`endif

    // reset at eof+12 aborts the frame
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 8'hC0);
    drive(0, 1, 0, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      sof = 0; eof = 0; pix_valid = 0;
    end
    check("busy_before_abort", busy, 1);
    rst = 1;
    #1;
    check("abort_id_value", id_value, 64'h0);
    check("abort_busy", busy, 0);
    check("abort_id_valid", id_valid, 0);
    check("abort_state", state_dbg, 0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 0;
    saw_valid = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (id_valid) saw_valid = 1;
    end
    check("no_valid_after_abort", saw_valid, 0);
    check("id_value_after_abort", id_value, 64'h0);

    // normal frame after abort
    drive(1, 0, 1, 8'h80);
    for (int i = 0; i < 40; i++) drive(0, 0, 1, 8'($urandom_range(0, 255)));
    drive(0, 1, 0, 8'h00);
    wait_result(0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
